uart_frame_loader: RTL
======================

// Module: uart_frame_loader
// PURPOSE
//  Receive-side framer between uart_rcvr and the detection pipeline: accepts one byte per uart_data_rdy
//  pulse, buffers bytes in a small FIFO, and streams them downstream as raster-ordered pixels with x/y tags.
//  Drives the RTS flow-control line (fpga_can_receive): deasserts it near FIFO full and for the whole period
//  from frame complete until the result bytes have gone back to the laptop.
//  Counterpart of the result-transmit path (results_to_uart); results_sent closes the handshake loop.
// PARAMETERS
//  FRAME_WIDTH   320  pixels per row (LAPTOP_WIDTH)
//  FRAME_HEIGHT  240  rows per frame (LAPTOP_HEIGHT)
//  FIFO_DEPTH    16   byte FIFO entries, power of 2, >= 4
//  RTS_SLACK     4    free entries reserved for bytes already in flight once rts falls
// PORTS
//  clock         in   1   system clock
//  reset         in   1   synchronous, active-high
//  uart_data     in   8   received byte from uart_rcvr
//  uart_data_rdy in   1   1-cycle strobe: uart_data valid
//  rts           out  1   fpga_can_receive; 1 = laptop may send
//  pixel         out  8   pixel value to pipeline
//  pixel_valid   out  1   pixel/pixel_x/pixel_y/pixel_last valid
//  pixel_ready   in   1   downstream accepts when valid&ready
//  pixel_x       out  16  column of current pixel
//  pixel_y       out  16  row of current pixel
//  pixel_last    out  1   current pixel is (FRAME_WIDTH-1, FRAME_HEIGHT-1)
//  frame_done    out  1   1-cycle pulse after last pixel handshake
//  results_sent  in   1   1-cycle pulse: result bytes fully transmitted
//  overflow      out  1   sticky: a received byte was dropped
// BEHAVIOUR
//  Reset (sync): state=IDLE, FIFO empty, rx_count=0, x=y=0; outputs: rts=1, pixel_valid=0, pixel=0,
//   pixel_last=0, frame_done=0, overflow=0. Reset mid-frame discards all buffered bytes, no frame_done.
//  FSM (frame_state_t):
//   IDLE : rts=1. uart_data_rdy -> push byte, rx_count=1, -> RECV.
//   RECV : rts = (free_entries > RTS_SLACK). Each accepted byte increments rx_count; when the byte
//          making rx_count == FRAME_WIDTH*FRAME_HEIGHT is accepted -> DRAIN (rts=0 from next cycle).
//   DRAIN: rts=0. FIFO empties downstream; handshake on pixel_last -> frame_done=1 next cycle, -> HOLD.
//   HOLD : rts=0. results_sent -> IDLE (rts=1 next cycle). results_sent outside HOLD is ignored.
//  Edge: 1x1 frame -> IDLE goes straight to DRAIN on the first byte.
//  FIFO: push accepted iff not full at cycle start and state in {IDLE,RECV}; otherwise byte dropped,
//   overflow<=1 (held until reset). Bytes in DRAIN/HOLD are dropped + overflow. Simultaneous push+pop
//   when non-empty: both occur, occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
//  Output: first-word-fall-through; byte accepted at cycle t is visible on pixel with pixel_valid=1 at
//   t+1 earliest. Outputs hold stable while pixel_valid & !pixel_ready (no drop, no change).
//  Coordinates: on handshake x<=x+1; at x==FRAME_WIDTH-1 x<=0, y<=y+1; after last pixel x=y=0.
//   pixel_last = (x==FRAME_WIDTH-1)&&(y==FRAME_HEIGHT-1), combinational from registered x/y.
//  rx_count 32-bit, never exceeds FRAME_WIDTH*FRAME_HEIGHT; cleared on entry to IDLE.
//  Throughput: one pixel per cycle when ready held high; no bubbles between frames beyond HOLD.
// STRUCTURE
//  Package vj_uart_pkg: typedef enum logic [1:0] {IDLE,RECV,DRAIN,HOLD} frame_state_t;
//   localparam FRAME_PIXELS = FRAME_WIDTH*FRAME_HEIGHT; coord width constant COORD_W = 16.
//  Sub-module byte_fifo (sync FWFT FIFO: push/pop/full/empty/count, sync reset), one instance.
//  Top level holds FSM, rx_count, x/y counters, rts and overflow registers.
// TESTING (bench params: FRAME_WIDTH=4, FRAME_HEIGHT=2, FIFO_DEPTH=4, RTS_SLACK=1)
//  Reset, then 8 bytes 0x10..0x17, ready=1 -> pixels 0x10..0x17, (x,y)=(0,0)..(3,1), pixel_last on 0x17,
//   one frame_done pulse, rts=0 until results_sent, rts=1 the cycle after.
//  ready=0, send 3 bytes -> rts falls when free_entries<=1; 4th byte accepted, 5th dropped, overflow=1.
//  ready toggled 1/0 every cycle over 8 bytes -> pixel/x/y stable while stalled, no loss or duplication.
//  Byte arriving in HOLD -> dropped, overflow=1, no pixel_valid; results_sent in RECV -> ignored.
//  reset asserted after 5 of 8 bytes -> next cycle rts=1, pixel_valid=0; new 8-byte frame starts at (0,0).
//  Two back-to-back frames with results_sent between -> second frame coords restart at (0,0), overflow=0.

Source files
------------

// File: rtl/vj_uart_pkg.sv
// Shared types and constants for the laptop-to-FPGA video receive path.
package vj_uart_pkg;

   localparam int unsigned LAPTOP_WIDTH  = 320;
   localparam int unsigned LAPTOP_HEIGHT = 240;
   localparam int unsigned FRAME_PIXELS  = LAPTOP_WIDTH * LAPTOP_HEIGHT;
   localparam int unsigned COORD_W       = 16;
   localparam int unsigned RX_COUNT_W    = 32;
   localparam int unsigned BYTE_W        = 8;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      DRAIN,
      HOLD
   } frame_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO; head entry is always visible on pop_data.
module byte_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage array carries no reset; occupancy tracking makes stale entries invisible.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/uart_frame_loader.sv
// Buffers UART bytes into raster-tagged pixels and manages RTS flow control per frame.
module uart_frame_loader
   import vj_uart_pkg::*;
#(
   parameter int unsigned FRAME_WIDTH  = LAPTOP_WIDTH,
   parameter int unsigned FRAME_HEIGHT = LAPTOP_HEIGHT,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned RTS_SLACK    = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [BYTE_W-1:0]  uart_data,
   input  logic               uart_data_rdy,
   output logic               rts,
   output logic [BYTE_W-1:0]  pixel,
   output logic               pixel_valid,
   input  logic               pixel_ready,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               pixel_last,
   output logic               frame_done,
   input  logic               results_sent,
   output logic               overflow
);

   localparam int unsigned NUM_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
   localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;

   frame_state_t          state;
   frame_state_t          state_d;
   logic [RX_COUNT_W-1:0] rx_count;
   logic [RX_COUNT_W-1:0] rx_count_d;
   logic                  rts_d;
   logic                  frame_done_d;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [BYTE_W-1:0]     fifo_data;
   logic [CW-1:0]         fifo_count;
   logic [CW-1:0]         count_next;
   logic                  accept;
   logic                  handshake;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (BYTE_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (accept),
      .push_data (uart_data),
      .pop       (handshake),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign pixel_valid = !fifo_empty;
   assign pixel       = pixel_valid ? fifo_data : '0;
   assign handshake   = pixel_valid && pixel_ready;
   assign pixel_last  = (pixel_x == COORD_W'(FRAME_WIDTH - 1)) &&
                        (pixel_y == COORD_W'(FRAME_HEIGHT - 1));
   assign accept      = uart_data_rdy && !fifo_full && ((state == IDLE) || (state == RECV));
   assign count_next  = fifo_count + CW'(accept) - CW'(handshake);

   // Next-state, byte counting and registered-output targets.
   always_comb begin
      state_d      = state;
      rx_count_d   = rx_count;
      rts_d        = 1'b0;
      frame_done_d = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               rx_count_d = RX_COUNT_W'(1);
               if (NUM_PIXELS == 1) begin
                  state_d = DRAIN;
               end else begin
                  state_d = RECV;
               end
            end
         end
         RECV: begin
            if (accept) begin
               rx_count_d = rx_count + RX_COUNT_W'(1);
               if (rx_count_d == RX_COUNT_W'(NUM_PIXELS)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (handshake && pixel_last) begin
               frame_done_d = 1'b1;
               state_d      = HOLD;
            end
         end
         HOLD: begin
            if (results_sent) begin
               rx_count_d = '0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // RTS keeps RTS_SLACK entries free for bytes the laptop already has in flight.
      case (state_d)
         IDLE:    rts_d = 1'b1;
         RECV:    rts_d = (count_next < CW'(FIFO_DEPTH - RTS_SLACK));
         default: rts_d = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         rx_count   <= '0;
         rts        <= 1'b1;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_d;
         rx_count   <= rx_count_d;
         rts        <= rts_d;
         frame_done <= frame_done_d;
         overflow   <= overflow || (uart_data_rdy && !accept);
      end
   end

   // Raster coordinates advance only on a downstream handshake.
   always_ff @(posedge clock) begin
      if (reset) begin
         pixel_x <= '0;
         pixel_y <= '0;
      end else if (handshake) begin
         if (pixel_x == COORD_W'(FRAME_WIDTH - 1)) begin
            pixel_x <= '0;
            if (pixel_y == COORD_W'(FRAME_HEIGHT - 1)) begin
               pixel_y <= '0;
            end else begin
               pixel_y <= pixel_y + COORD_W'(1);
            end
         end else begin
            pixel_x <= pixel_x + COORD_W'(1);
         end
      end
   end

endmodule
